// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed N-digit 7-segment display driver. Holds a
//                double-buffered frame of BCD digits and scans one digit per
//                slot. Each slot opens with a short all-off blanking interval
//                to suppress ghosting. Supports per-digit blink and
//                leading-zero suppression. Codes 10-15 display blank.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   clock       in   1              system clock
//   reset       in   1              asynchronous, active-high
//   enable      in   1              0: display dark, scan/blink counters held
//   bcd_in      in   4*NUM_DIGITS   digit i = bcd_in[4i+3:4i]
//   load        in   1              capture bcd_in/dp_in into pending frame
//   dp_in       in   NUM_DIGITS     decimal point per digit
//   blink_mask  in   NUM_DIGITS     digits that blink while blink_en=1
//   blink_en    in   1              blink enable
//   seg_out     out  7              {A,B,C,D,E,F,G}, seg_out[6]=A
//   dp_out      out  1              decimal point of the active digit
//   dig_sel     out  NUM_DIGITS     one-hot digit enable
//   frame_done  out  1              1-cycle pulse as the last digit slot ends
// ============================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 0,
  parameter int LZ_BLANK     = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS-1:0]   bcd_in,
  input  logic                      load,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      blink_en,
  output logic [6:0]                seg_out,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     dig_sel,
  output logic                      frame_done
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0]      c_cnt_last  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      c_blank_end = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      c_idx_last  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0]      c_frm_last  = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] c_dig_one   = NUM_DIGITS'(1);

  // Output polarity: XOR masks that turn active-high internal values into
  // pin levels. The same masks are the inactive (reset) pin levels.
  localparam logic                  c_pol       = (ACTIVE_LOW != 0);
  localparam logic [6:0]            c_seg_off   = {7{c_pol}};
  localparam logic [NUM_DIGITS-1:0] c_dig_off   = {NUM_DIGITS{c_pol}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]        scan_cnt_q,  scan_cnt_d;
  logic [IDX_W-1:0]        idx_q,       idx_d;
  logic [FRM_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic                    blink_ph_q,  blink_ph_d;

  logic [4*NUM_DIGITS-1:0] pend_bcd_q,  pend_bcd_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q,   pend_dp_d;
  logic [4*NUM_DIGITS-1:0] act_bcd_q,   act_bcd_d;
  logic [NUM_DIGITS-1:0]   act_dp_q,    act_dp_d;

  logic [6:0]              seg_q,       seg_d;
  logic                    dp_q,        dp_d;
  logic [NUM_DIGITS-1:0]   dig_q,       dig_d;
  logic                    frame_done_q, frame_done_d;

  // --------------------------------------------------------------------------
  // Decode A..G for one BCD digit; codes 10-15 are dark.
  // --------------------------------------------------------------------------
  function automatic logic [6:0] f_decode(input logic [3:0] digit);
    logic [6:0] segs;
    case (digit)
      4'd0:    segs = 7'b1111110;
      4'd1:    segs = 7'b0110000;
      4'd2:    segs = 7'b1101101;
      4'd3:    segs = 7'b1111001;
      4'd4:    segs = 7'b0110011;
      4'd5:    segs = 7'b1011011;
      4'd6:    segs = 7'b1011111;
      4'd7:    segs = 7'b1110000;
      4'd8:    segs = 7'b1111111;
      4'd9:    segs = 7'b1111011;
      default: segs = 7'b0000000;
    endcase
    return segs;
  endfunction

  // --------------------------------------------------------------------------
  // Scan timing
  // --------------------------------------------------------------------------
  logic w_slot_end;
  logic w_frame_wrap;

  assign w_slot_end   = (scan_cnt_q == c_cnt_last);
  // The frame wraps on the final cycle of the last digit slot. Nothing in the
  // scan advances while disabled, so a wrap can only happen when enabled.
  assign w_frame_wrap = enable && w_slot_end && (idx_q == c_idx_last);

  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (enable) begin
      if (w_slot_end) begin
        scan_cnt_d = '0;
        idx_d      = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
      end else begin
        scan_cnt_d = scan_cnt_q + 1'b1;
      end
      if (w_frame_wrap) begin
        if (frame_cnt_q == c_frm_last) begin
          frame_cnt_d = '0;
          blink_ph_d  = ~blink_ph_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame buffers
  // The pending frame takes every load. The active frame, which the scan
  // reads, only changes at a frame wrap (so a frame never tears mid-scan) or
  // while the display is disabled (nothing is being scanned then). Taking
  // pend_*_d at the wrap lets a load on the wrap cycle land directly.
  // --------------------------------------------------------------------------
  always_comb begin
    pend_bcd_d = pend_bcd_q;
    pend_dp_d  = pend_dp_q;
    act_bcd_d  = act_bcd_q;
    act_dp_d   = act_dp_q;
    if (load) begin
      pend_bcd_d = bcd_in;
      pend_dp_d  = dp_in;
    end
    if (!enable) begin
      if (load) begin
        act_bcd_d = bcd_in;
        act_dp_d  = dp_in;
      end
    end else if (w_frame_wrap) begin
      act_bcd_d = pend_bcd_d;
      act_dp_d  = pend_dp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Active-frame digit view and leading-zero run
  // --------------------------------------------------------------------------
  logic [3:0]            w_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_lz_blank;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign w_digit[gi] = act_bcd_q[4*gi +: 4];
  end

  // w_lz_blank[i] is set when digit i and every digit above it are zero.
  // Digit 0 is never suppressed, so bit 0 stays clear.
  always_comb begin
    logic run_zero;
    run_zero   = 1'b1;
    w_lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run_zero      = run_zero && (w_digit[i] == 4'd0);
      w_lz_blank[i] = run_zero;
    end
  end

  // --------------------------------------------------------------------------
  // Slot output (registered one cycle behind the scan state)
  // Blink darkens segments and decimal point but keeps the digit strobe, so
  // scan brightness does not shift. Leading-zero suppression darkens the
  // segments only; the decimal point of a suppressed digit still shows.
  // --------------------------------------------------------------------------
  logic [3:0]            w_cur_digit;
  logic                  w_blink_off;
  logic                  w_lz_off;
  logic [6:0]            w_seg_act;
  logic                  w_dp_act;
  logic [NUM_DIGITS-1:0] w_dig_act;

  assign w_cur_digit = w_digit[idx_q];
  assign w_blink_off = blink_en && blink_ph_q && blink_mask[idx_q];
  assign w_lz_off    = (LZ_BLANK != 0) && w_lz_blank[idx_q];

  always_comb begin
    w_seg_act = '0;
    w_dp_act  = 1'b0;
    w_dig_act = '0;
    if (enable && (scan_cnt_q >= c_blank_end)) begin
      w_dig_act = c_dig_one << idx_q;
      if (!w_blink_off) begin
        w_dp_act = act_dp_q[idx_q];
        if (!w_lz_off) begin
          w_seg_act = f_decode(w_cur_digit);
        end
      end
    end
    seg_d        = w_seg_act ^ c_seg_off;
    dp_d         = w_dp_act ^ c_pol;
    dig_d        = w_dig_act ^ c_dig_off;
    frame_done_d = w_frame_wrap;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      frame_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      act_bcd_q    <= '0;
      act_dp_q     <= '0;
      seg_q        <= c_seg_off;
      dp_q         <= c_pol;
      dig_q        <= c_dig_off;
      frame_done_q <= 1'b0;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_ph_q   <= blink_ph_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_dp_q    <= pend_dp_d;
      act_bcd_q    <= act_bcd_d;
      act_dp_q     <= act_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_sel    = dig_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
